pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards, sequences multi-cycle data-memory accesses in MEM, and redirects the PC on branch/jump resolved in MEM.
//  Drives write-enable and flush (bubble) controls of every stage register plus the PC; latches a fatal timeout.
// PARAMETERS
//  MEM_TIMEOUT  default 16  max cycles MEM_WAIT may last before the fatal timeout (>=1)
//  REG_AW       default 5   register-address width
// PORTS
//  Clock         in   1       pipeline clock, rising edge
//  Reset_n       in   1       asynchronous, active-low reset
//  IdRs          in   REG_AW  rs of instruction in ID
//  IdRt          in   REG_AW  rt of instruction in ID
//  IdUsesRt      in   1       ID instruction reads rt
//  ExMemRead     in   1       EX instruction is a load
//  ExRd          in   REG_AW  selected destination register of EX instruction
//  MemReq        in   1       MEM instruction accesses data memory (read or write enable)
//  MemReady      in   1       data memory completes access this cycle
//  MemRedirect   in   1       MEM instruction is a taken branch or jump
//  PcWriteEn     out  1       PC load enable
//  PcSel         out  1       1 = PC takes redirect target
//  IfIdWriteEn   out  1       IF/ID register enable
//  IdExWriteEn   out  1       ID/EX register enable
//  ExMemWriteEn  out  1       EX/MEM register enable
//  MemWbWriteEn  out  1       MEM/WB register enable
//  IfIdFlush     out  1       IF/ID loads bubble
//  IdExFlush     out  1       ID/EX loads bubble
//  ExMemFlush    out  1       EX/MEM loads bubble
//  MemWbFlush    out  1       MEM/WB loads bubble
//  MemTimeout    out  1       sticky fatal timeout flag
// BEHAVIOUR
//  - States: RUN, MEM_WAIT, HALT. Reset_n low: state=RUN, WaitCnt=0, MemTimeout=0, all enables 0, all flushes 0, PcSel 0.
//  - Outputs are combinational decode of state and inputs (zero-latency stall); state, WaitCnt, MemTimeout are registered.
//  - Default (RUN, no hazard): all WriteEn=1, all Flush=0, PcSel=0.
//  - Priority in RUN: mem-stall > redirect > load-use.
//  - Mem-stall: MemReq & ~MemReady -> PC, IF/ID, ID/EX, EX/MEM enables 0; MemWbFlush=1; next state MEM_WAIT, WaitCnt<=1.
//  - MEM_WAIT: same outputs while ~MemReady; WaitCnt increments each cycle.
//    MemReady=1 -> default outputs this cycle (redirect/load-use rules apply), next state RUN, WaitCnt<=0.
//    WaitCnt==MEM_TIMEOUT & ~MemReady -> next state HALT, MemTimeout<=1.
//  - Redirect: MemRedirect=1 -> PcSel=1, PcWriteEn=1, IfIdFlush=IdExFlush=ExMemFlush=1; single cycle.
//  - Load-use: ExMemRead & ExRd!=0 & (ExRd==IdRs | (IdUsesRt & ExRd==IdRt)) -> PcWriteEn=0, IfIdWriteEn=0, IdExFlush=1.
//    Exactly one bubble; the next cycle the load has left EX and the condition clears.
//  - Redirect and load-use in the same cycle: redirect outputs only.
//  - Redirect during a mem-stall: held in EX/MEM and acted on in the MemReady cycle.
//  - HALT: all enables 0, all flushes 0, MemTimeout=1; exit only by reset.
//  - Reset asserted mid-MEM_WAIT: immediate return to RUN, counter cleared.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    adds outputs StallCycles[31:0] and FlushEvents[31:0], saturating, reset 0.
//    StallCycles counts cycles with PcWriteEn=0 outside HALT.
//    FlushEvents counts redirect cycles.
//  HAZARD_PERF_EN undefined: ports and counters absent; otherwise identical behaviour.
// STRUCTURE
//  pipe_ctrl_pkg holds:
//    state encoding RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2
//    stage index constants
//    bubble/enable default vectors
//  Sub-module load_use_detect (combinational compare, REG_AW param) instantiated once.
// TESTING
//  1 ExMemRead=1, ExRd=8, IdRs=8 -> one cycle PcWriteEn=0, IfIdWriteEn=0, IdExFlush=1; defaults next cycle.
//  2 ExMemRead=1, ExRd=0, IdRs=0 -> no stall.
//  3 MemReq=1, MemReady low for 3 cycles then 1 -> 3 cycles stalled with MemWbFlush=1; RUN and defaults on cycle 4.
//  4 MemRedirect=1 together with a load-use hit -> PcSel=1, flushes IF/ID, ID/EX, EX/MEM set; PcWriteEn=1.
//  5 MemReq=1, MemReady=0 held for MEM_TIMEOUT=4 -> MemTimeout=1, all enables 0 thereafter; Reset_n pulse -> RUN.
//  6 Reset_n low during MEM_WAIT cycle 2 -> outputs 0 immediately; after release, defaults with MemReq=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, stage
// indices and the enable/bubble control vectors for each pipeline situation.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  // Stage register indices; the enable vector carries the PC one bit above MEM/WB.
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;
  localparam int STG_PC    = 4;

  localparam logic [4:0] EN_ALL       = 5'b11111;
  localparam logic [4:0] EN_NONE      = 5'b00000;
  localparam logic [4:0] EN_MEM_STALL = 5'b01000;
  localparam logic [4:0] EN_LOAD_USE  = 5'b01110;

  localparam logic [3:0] FL_NONE      = 4'b0000;
  localparam logic [3:0] FL_MEM_STALL = 4'b1000;
  localparam logic [3:0] FL_REDIRECT  = 4'b0111;
  localparam logic [3:0] FL_LOAD_USE  = 4'b0010;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hit
);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign hit = ex_mem_read && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline registers and the PC.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush counters.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_AW      = 5
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [REG_AW-1:0] IdRs,
  input  logic [REG_AW-1:0] IdRt,
  input  logic              IdUsesRt,
  input  logic              ExMemRead,
  input  logic [REG_AW-1:0] ExRd,
  input  logic              MemReq,
  input  logic              MemReady,
  input  logic              MemRedirect,
  output logic              PcWriteEn,
  output logic              PcSel,
  output logic              IfIdWriteEn,
  output logic              IdExWriteEn,
  output logic              ExMemWriteEn,
  output logic              MemWbWriteEn,
  output logic              IfIdFlush,
  output logic              IdExFlush,
  output logic              ExMemFlush,
  output logic              MemWbFlush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushEvents,
`endif
  output logic              MemTimeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             timeout_q, timeout_next;
  logic             lu_hit;
  logic             stall;
  logic [4:0]       en;
  logic [3:0]       fl;
  logic             pc_sel;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_mem_read (ExMemRead),
    .ex_rd       (ExRd),
    .id_rs       (IdRs),
    .id_rt       (IdRt),
    .id_uses_rt  (IdUsesRt),
    .hit         (lu_hit)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      timeout_q <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_next  = timeout_q;
    case (state)
      RUN: begin
        if (MemReq && !MemReady) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (MemReady) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
          state_next   = HALT;
          timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // Zero-latency decode: a memory stall hides any redirect still held in EX/MEM.
  always_comb begin
    en     = EN_NONE;
    fl     = FL_NONE;
    pc_sel = 1'b0;
    stall  = ((state == RUN) && MemReq && !MemReady) ||
             ((state == MEM_WAIT) && !MemReady);
    if (Reset_n && (state == RUN || state == MEM_WAIT)) begin
      if (stall) begin
        en = EN_MEM_STALL;
        fl = FL_MEM_STALL;
      end else if (MemRedirect) begin
        en     = EN_ALL;
        fl     = FL_REDIRECT;
        pc_sel = 1'b1;
      end else if (lu_hit) begin
        en = EN_LOAD_USE;
        fl = FL_LOAD_USE;
      end else begin
        en = EN_ALL;
        fl = FL_NONE;
      end
    end
  end

  assign PcWriteEn    = en[STG_PC];
  assign PcSel        = pc_sel;
  assign IfIdWriteEn  = en[STG_IFID];
  assign IdExWriteEn  = en[STG_IDEX];
  assign ExMemWriteEn = en[STG_EXMEM];
  assign MemWbWriteEn = en[STG_MEMWB];
  assign IfIdFlush    = fl[STG_IFID];
  assign IdExFlush    = fl[STG_IDEX];
  assign ExMemFlush   = fl[STG_EXMEM];
  assign MemWbFlush   = fl[STG_MEMWB];
  assign MemTimeout   = timeout_q;

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (state != HALT && !en[STG_PC]) StallCycles <= sat_inc(StallCycles);
      if (pc_sel)                       FlushEvents <= sat_inc(FlushEvents);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller with MEM_TIMEOUT=4.
module tb_pipeline_hazard_controller;

  localparam int REG_AW = 5;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic [REG_AW-1:0] IdRs, IdRt, ExRd;
  logic              IdUsesRt, ExMemRead, MemReq, MemReady, MemRedirect;
  logic              PcWriteEn, PcSel, IfIdWriteEn, IdExWriteEn, ExMemWriteEn, MemWbWriteEn;
  logic              IfIdFlush, IdExFlush, ExMemFlush, MemWbFlush, MemTimeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]       StallCycles, FlushEvents;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Order: PcWE PcSel IfIdWE IdExWE ExMemWE MemWbWE IfIdF IdExF ExMemF MemWbF Timeout
  localparam logic [10:0] V_ZERO = 11'b0_0_0000_0000_0;
  localparam logic [10:0] V_DEF  = 11'b1_0_1111_0000_0;
  localparam logic [10:0] V_LU   = 11'b0_0_0111_0100_0;
  localparam logic [10:0] V_MST  = 11'b0_0_0001_0001_0;
  localparam logic [10:0] V_RED  = 11'b1_1_1111_1110_0;
  localparam logic [10:0] V_HALT = 11'b0_0_0000_0000_1;

  logic [10:0] obs;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .REG_AW(REG_AW)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .IdRs         (IdRs),
    .IdRt         (IdRt),
    .IdUsesRt     (IdUsesRt),
    .ExMemRead    (ExMemRead),
    .ExRd         (ExRd),
    .MemReq       (MemReq),
    .MemReady     (MemReady),
    .MemRedirect  (MemRedirect),
    .PcWriteEn    (PcWriteEn),
    .PcSel        (PcSel),
    .IfIdWriteEn  (IfIdWriteEn),
    .IdExWriteEn  (IdExWriteEn),
    .ExMemWriteEn (ExMemWriteEn),
    .MemWbWriteEn (MemWbWriteEn),
    .IfIdFlush    (IfIdFlush),
    .IdExFlush    (IdExFlush),
    .ExMemFlush   (ExMemFlush),
    .MemWbFlush   (MemWbFlush),
`ifdef HAZARD_PERF_EN
    .StallCycles  (StallCycles),
    .FlushEvents  (FlushEvents),
`endif
    .MemTimeout   (MemTimeout)
  );

  always #5 Clock = ~Clock;

  assign obs = {PcWriteEn, PcSel, IfIdWriteEn, IdExWriteEn, ExMemWriteEn, MemWbWriteEn,
                IfIdFlush, IdExFlush, ExMemFlush, MemWbFlush, MemTimeout};

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    IdRs = '0; IdRt = '0; ExRd = '0;
    IdUsesRt = 1'b0; ExMemRead = 1'b0;
    MemReq = 1'b0; MemReady = 1'b0; MemRedirect = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    idle_inputs();
    #2;
    vectors++;
    if (obs !== V_ZERO) begin
      $display("FAIL reset_hold: got %b want %b", obs, V_ZERO); miscompares++;
    end
    next_cycle();
    Reset_n = 1'b1;
    #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL reset_release_default: got %b want %b", obs, V_DEF); miscompares++;
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    ExMemRead = 1'b1; ExRd = 5'd8; IdRs = 5'd8; #1;
    vectors++;
    if (obs !== V_LU) begin
      $display("FAIL load_use_rs: got %b want %b", obs, V_LU); miscompares++;
    end
    next_cycle();
    ExMemRead = 1'b0; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL load_use_after: got %b want %b", obs, V_DEF); miscompares++;
    end
    next_cycle();
    ExMemRead = 1'b1; ExRd = 5'd8; IdRs = 5'd3; IdRt = 5'd8; IdUsesRt = 1'b1; #1;
    vectors++;
    if (obs !== V_LU) begin
      $display("FAIL load_use_rt: got %b want %b", obs, V_LU); miscompares++;
    end
    IdUsesRt = 1'b0; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL load_use_rt_unused: got %b want %b", obs, V_DEF); miscompares++;
    end
    next_cycle();
    ExMemRead = 1'b1; ExRd = 5'd0; IdRs = 5'd0; IdRt = 5'd0; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL load_use_r0: got %b want %b", obs, V_DEF); miscompares++;
    end
    idle_inputs();
  endtask

  task automatic test_mem_stall();
    next_cycle();
    MemReq = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (obs !== V_MST) begin
        $display("FAIL mem_stall_cycle%0d: got %b want %b", i + 1, obs, V_MST); miscompares++;
      end
      next_cycle();
    end
    MemReady = 1'b1; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL mem_stall_ready: got %b want %b", obs, V_DEF); miscompares++;
    end
    next_cycle();
    MemReq = 1'b0; MemReady = 1'b0; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL mem_stall_back_in_run: got %b want %b", obs, V_DEF); miscompares++;
    end
  endtask

  task automatic test_redirect_load_use();
    next_cycle();
    MemRedirect = 1'b1; ExMemRead = 1'b1; ExRd = 5'd9; IdRs = 5'd9; #1;
    vectors++;
    if (obs !== V_RED) begin
      $display("FAIL redirect_over_load_use: got %b want %b", obs, V_RED); miscompares++;
    end
    next_cycle();
    idle_inputs(); #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL redirect_single_cycle: got %b want %b", obs, V_DEF); miscompares++;
    end
  endtask

  task automatic test_redirect_in_stall();
    next_cycle();
    MemReq = 1'b1; MemReady = 1'b0; MemRedirect = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (obs !== V_MST) begin
        $display("FAIL stall_hides_redirect%0d: got %b want %b", i + 1, obs, V_MST); miscompares++;
      end
      next_cycle();
    end
    MemReady = 1'b1; #1;
    vectors++;
    if (obs !== V_RED) begin
      $display("FAIL redirect_on_ready: got %b want %b", obs, V_RED); miscompares++;
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_timeout();
    next_cycle();
    MemReq = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (obs !== V_MST) begin
        $display("FAIL timeout_stall%0d: got %b want %b", i + 1, obs, V_MST); miscompares++;
      end
      next_cycle();
    end
    #1;
    vectors++;
    if (obs !== V_HALT) begin
      $display("FAIL timeout_halt: got %b want %b", obs, V_HALT); miscompares++;
    end
    next_cycle();
    MemReady = 1'b1; MemRedirect = 1'b1; #1;
    vectors++;
    if (obs !== V_HALT) begin
      $display("FAIL halt_sticky: got %b want %b", obs, V_HALT); miscompares++;
    end
    next_cycle();
    Reset_n = 1'b0; idle_inputs(); #1;
    vectors++;
    if (obs !== V_ZERO) begin
      $display("FAIL halt_reset: got %b want %b", obs, V_ZERO); miscompares++;
    end
    next_cycle();
    Reset_n = 1'b1; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL halt_exit_run: got %b want %b", obs, V_DEF); miscompares++;
    end
  endtask

  task automatic test_reset_mid_wait();
    next_cycle();
    MemReq = 1'b1; MemReady = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    vectors++;
    if (obs !== V_MST) begin
      $display("FAIL midwait_stall: got %b want %b", obs, V_MST); miscompares++;
    end
    Reset_n = 1'b0; #1;
    vectors++;
    if (obs !== V_ZERO) begin
      $display("FAIL midwait_reset_immediate: got %b want %b", obs, V_ZERO); miscompares++;
    end
    next_cycle();
    Reset_n = 1'b1; MemReq = 1'b0; #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL midwait_release: got %b want %b", obs, V_DEF); miscompares++;
    end
    next_cycle();
    #1;
    vectors++;
    if (obs !== V_DEF) begin
      $display("FAIL midwait_run_kept: got %b want %b", obs, V_DEF); miscompares++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_mem_stall();
    test_redirect_load_use();
    test_redirect_in_stall();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
